// File: rtl/ipv4_tcp_extractor.sv
// ipv4_tcp_extractor: parses a byte stream of IPv4 datagrams, validates the
// header, skips IP options and forwards only the TCP segment bytes, registered
// with one cycle of latency. Rejected datagrams raise hdr_drop with a reason.
// Optional feature macro: IPV4_CSUM_CHECK_EN enables header checksum checking
// (drop reason 2). Without it the checksum field is ignored.
//
// Handshake: data_valid qualifies data_in for one cycle; there is no
// backpressure. tcp_valid qualifies tcp_data/tcp_start/tcp_end for one cycle.
// hdr_drop is a single-cycle pulse with drop_reason valid alongside it.
module ipv4_tcp_extractor #(
  parameter logic [7:0] PROTO_NUM   = 8'd6,
  parameter int         MIN_SEG_LEN = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  input  logic        frame_start,
  output logic [7:0]  tcp_data,
  output logic        tcp_valid,
  output logic        tcp_start,
  output logic        tcp_end,
  output logic [31:0] src_ip,
  output logic [31:0] dst_ip,
  output logic        hdr_drop,
  output logic [1:0]  drop_reason,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_OPTS    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  state_t      state;
  logic [5:0]  byte_cnt;
  logic [3:0]  ihl;
  logic [15:0] total_len;
  logic [31:0] src_sh;
  logic [31:0] dst_sh;
  logic [15:0] seg_rem;
  logic        first_seg;

  // Header geometry and length check, evaluated at the last header byte
  logic [5:0]  hdr_bytes;
  logic        last_hdr;
  logic [16:0] min_total;
  logic        len_ok;
  logic [15:0] seg_len;
  logic [31:0] dst_full;

  assign hdr_bytes = {ihl, 2'b00};
  assign last_hdr  = (byte_cnt == (hdr_bytes - 6'd1));
  assign min_total = {11'd0, hdr_bytes} + 17'(MIN_SEG_LEN);
  assign len_ok    = ({1'b0, total_len} >= min_total);
  assign seg_len   = total_len - {10'd0, hdr_bytes};
  // Byte 19 is the last destination byte; when it is also the last header
  // byte the shadow register has not captured it yet.
  assign dst_full  = (byte_cnt == 6'd19) ? {dst_sh[31:8], data_in} : dst_sh;
  assign state_dbg = state;

`ifdef IPV4_CSUM_CHECK_EN
  logic [15:0] csum_acc;
  logic [15:0] csum_word;
  logic [16:0] csum_sum;
  logic [15:0] csum_next;
  logic        csum_bad;

  // Even header bytes are the high half of a word, odd bytes the low half;
  // the ones'-complement sum is order independent so bytes add one at a time.
  assign csum_word = byte_cnt[0] ? {8'h00, data_in} : {data_in, 8'h00};
  assign csum_sum  = {1'b0, csum_acc} + {1'b0, csum_word};
  assign csum_next = csum_sum[15:0] + {15'd0, csum_sum[16]};
  assign csum_bad  = (csum_next != 16'hFFFF);

  // Checksum accumulator, restarted by every frame_start byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum_acc <= 16'd0;
    end else if (data_valid) begin
      if (frame_start) begin
        csum_acc <= {data_in, 8'h00};
      end else if (state == S_HDR || state == S_OPTS) begin
        csum_acc <= csum_next;
      end
    end
  end
`else
  logic csum_bad;
  assign csum_bad = 1'b0;
`endif

  // Parser FSM with registered stream and drop outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      byte_cnt    <= 6'd0;
      ihl         <= 4'd0;
      total_len   <= 16'd0;
      src_sh      <= 32'd0;
      dst_sh      <= 32'd0;
      seg_rem     <= 16'd0;
      first_seg   <= 1'b0;
      tcp_data    <= 8'd0;
      tcp_valid   <= 1'b0;
      tcp_start   <= 1'b0;
      tcp_end     <= 1'b0;
      src_ip      <= 32'd0;
      dst_ip      <= 32'd0;
      hdr_drop    <= 1'b0;
      drop_reason <= 2'd0;
    end else begin
      tcp_valid <= 1'b0;
      tcp_start <= 1'b0;
      tcp_end   <= 1'b0;
      hdr_drop  <= 1'b0;
      if (data_valid) begin
        if (frame_start) begin
          byte_cnt <= 6'd1;
          ihl      <= data_in[3:0];
          if (data_in[7:4] != 4'd4 || data_in[3:0] < 4'd5) begin
            state       <= S_DROP;
            hdr_drop    <= 1'b1;
            drop_reason <= 2'd0;
          end else begin
            state <= S_HDR;
          end
        end else begin
          case (state)
            S_HDR, S_OPTS: begin
              byte_cnt <= byte_cnt + 6'd1;
              case (byte_cnt)
                6'd2:  total_len[15:8] <= data_in;
                6'd3:  total_len[7:0]  <= data_in;
                6'd12: src_sh[31:24]   <= data_in;
                6'd13: src_sh[23:16]   <= data_in;
                6'd14: src_sh[15:8]    <= data_in;
                6'd15: src_sh[7:0]     <= data_in;
                6'd16: dst_sh[31:24]   <= data_in;
                6'd17: dst_sh[23:16]   <= data_in;
                6'd18: dst_sh[15:8]    <= data_in;
                6'd19: dst_sh[7:0]     <= data_in;
                default: ;
              endcase
              if (byte_cnt == 6'd9 && data_in != PROTO_NUM) begin
                state       <= S_DROP;
                hdr_drop    <= 1'b1;
                drop_reason <= 2'd1;
              end else if (last_hdr) begin
                if (csum_bad) begin
                  state       <= S_DROP;
                  hdr_drop    <= 1'b1;
                  drop_reason <= 2'd2;
                end else if (!len_ok) begin
                  state       <= S_DROP;
                  hdr_drop    <= 1'b1;
                  drop_reason <= 2'd3;
                end else begin
                  state     <= S_PAYLOAD;
                  src_ip    <= src_sh;
                  dst_ip    <= dst_full;
                  seg_rem   <= seg_len;
                  first_seg <= 1'b1;
                end
              end else if (byte_cnt == 6'd19) begin
                state <= S_OPTS;
              end
            end
            S_PAYLOAD: begin
              tcp_valid <= 1'b1;
              tcp_data  <= data_in;
              tcp_start <= first_seg;
              tcp_end   <= (seg_rem == 16'd1);
              first_seg <= 1'b0;
              seg_rem   <= seg_rem - 16'd1;
              if (seg_rem == 16'd1) state <= S_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
